// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with two write ports, claim port and per-register pending scoreboard (optional REGFILE_BYPASS_EN)
module regfile_sb #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             busy1,
    output logic             busy2,
    input  logic             we3,
    input  logic [AW-1:0]    wa3,
    input  logic [WIDTH-1:0] wd3,
    input  logic             we4,
    input  logic [AW-1:0]    wa4,
    input  logic [WIDTH-1:0] wd4,
    input  logic             cl,
    input  logic [AW-1:0]    ca
);

    logic [WIDTH-1:0] rf_q [DEPTH];
    logic [WIDTH-1:0] rf_d [DEPTH];
    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;

    logic             wr_a;
    logic             wr_b;
    logic             clm;

    // Register 0 is hardwired: writes and claims aimed at it are dropped.
    assign wr_a = we3 && (wa3 != '0);
    assign wr_b = we4 && (wa4 != '0);
    assign clm  = cl  && (ca  != '0);

    // Next state: port B first so port A overrides on collision; claim applied last so it wins over a write.
    always_comb begin
        rf_d   = rf_q;
        pend_d = pend_q;
        if (wr_b) begin
            rf_d[wa4]   = wd4;
            pend_d[wa4] = 1'b0;
        end
        if (wr_a) begin
            rf_d[wa3]   = wd3;
            pend_d[wa3] = 1'b0;
        end
        if (clm) begin
            pend_d[ca] = 1'b1;
        end
    end

    // State register; reset overrides any write or claim in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
            pend_q <= '0;
        end else begin
            rf_q   <= rf_d;
            pend_q <= pend_d;
        end
    end

    logic [AW-1:0]    ra_v   [2];
    logic [WIDTH-1:0] rd_v   [2];
    logic             busy_v [2];

    assign ra_v[0] = ra1;
    assign ra_v[1] = ra2;
    assign rd1     = rd_v[0];
    assign rd2     = rd_v[1];
    assign busy1   = busy_v[0];
    assign busy2   = busy_v[1];

    // Combinational read of both ports; address 0 always reads as zero and idle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_v[p]   = rf_q[ra_v[p]];
            busy_v[p] = pend_q[ra_v[p]];
`ifdef REGFILE_BYPASS_EN
            if (!reset) begin
                if (wr_a && (wa3 == ra_v[p])) begin
                    rd_v[p]   = wd3;
                    busy_v[p] = clm && (ca == ra_v[p]);
                end else if (wr_b && (wa4 == ra_v[p])) begin
                    rd_v[p]   = wd4;
                    busy_v[p] = clm && (ca == ra_v[p]);
                end
            end
`endif
            if (ra_v[p] == '0) begin
                rd_v[p]   = '0;
                busy_v[p] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic             clk = 1'b0;
    logic             reset;
    logic [AW-1:0]    ra1, ra2;
    logic [WIDTH-1:0] rd1, rd2;
    logic             busy1, busy2;
    logic             we3, we4, cl;
    logic [AW-1:0]    wa3, wa4, ca;
    logic [WIDTH-1:0] wd3, wd4;

    int vectors    = 0;
    int miscompares = 0;

    regfile_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .ra1   (ra1),
        .ra2   (ra2),
        .rd1   (rd1),
        .rd2   (rd2),
        .busy1 (busy1),
        .busy2 (busy2),
        .we3   (we3),
        .wa3   (wa3),
        .wd3   (wd3),
        .we4   (we4),
        .wa4   (wa4),
        .wd4   (wd4),
        .cl    (cl),
        .ca    (ca)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        we3 = 1'b0; wa3 = '0; wd3 = '0;
        we4 = 1'b0; wa4 = '0; wd4 = '0;
        cl  = 1'b0; ca  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read1(input logic [AW-1:0] a);
        ra1 = a;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ra1 = '0; ra2 = '0;
        idle();
        tick();
        tick();
        reset = 1'b0;

        // all addresses read zero and idle after reset
        for (int i = 0; i < DEPTH; i++) begin
            ra1 = AW'(i);
            ra2 = AW'(DEPTH - 1 - i);
            #1;
            check($sformatf("rst_rd1[%0d]", i), rd1, 0);
            check($sformatf("rst_busy1[%0d]", i), busy1, 0);
            check($sformatf("rst_rd2[%0d]", DEPTH - 1 - i), rd2, 0);
            check($sformatf("rst_busy2[%0d]", DEPTH - 1 - i), busy2, 0);
        end

        // simple write, then write to r0 ignored
        we3 = 1'b1; wa3 = 5'd5; wd3 = 32'hDEADBEEF;
        tick(); idle();
        read1(5'd5);
        check("wr_r5", rd1, 32'hDEADBEEF);
        we3 = 1'b1; wa3 = 5'd0; wd3 = 32'h1234;
        tick(); idle();
        ra2 = 5'd0; #1;
        check("wr_r0_rd2", rd2, 0);
        check("wr_r0_busy2", busy2, 0);

        // port collision: A wins; distinct addresses both land
        we3 = 1'b1; wa3 = 5'd7; wd3 = 32'h11;
        we4 = 1'b1; wa4 = 5'd7; wd4 = 32'h22;
        tick(); idle();
        read1(5'd7);
        check("collide_r7", rd1, 32'h11);
        we3 = 1'b1; wa3 = 5'd8; wd3 = 32'h33;
        we4 = 1'b1; wa4 = 5'd9; wd4 = 32'h44;
        tick(); idle();
        ra1 = 5'd8; ra2 = 5'd9; #1;
        check("dual_r8", rd1, 32'h33);
        check("dual_r9", rd2, 32'h44);

        // claim holds pending, write through B clears it, claim+write keeps it
        cl = 1'b1; ca = 5'd10;
        tick(); idle();
        ra1 = 5'd10;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("claim_busy_c%0d", i), busy1, 1);
            tick();
        end
        cl = 1'b1; ca = 5'd10;
        tick(); idle();
        #1;
        check("reclaim_busy", busy1, 1);
        we4 = 1'b1; wa4 = 5'd10; wd4 = 32'h55;
        tick(); idle();
        read1(5'd10);
        check("wb_busy_clr", busy1, 0);
        check("wb_data", rd1, 32'h55);
        cl = 1'b1; ca = 5'd10;
        we3 = 1'b1; wa3 = 5'd10; wd3 = 32'h66;
        tick(); idle();
        read1(5'd10);
        check("claim_wins_busy", busy1, 1);
        check("claim_wins_data", rd1, 32'h66);

        // claim on r0 ignored; unaddressed registers untouched
        cl = 1'b1; ca = 5'd0;
        tick(); idle();
        read1(5'd0);
        check("claim_r0_busy", busy1, 0);
        read1(5'd8);
        check("keep_r8", rd1, 32'h33);
        read1(5'd5);
        check("keep_r5", rd1, 32'hDEADBEEF);

        // same-cycle read of a register being written
        we3 = 1'b1; wa3 = 5'd12; wd3 = 32'h1111;
        tick(); idle();
        ra1 = 5'd12;
        we3 = 1'b1; wa3 = 5'd12; wd3 = 32'hABCD;
        ra2 = 5'd13;
        we4 = 1'b1; wa4 = 5'd13; wd4 = 32'h77;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass_a", rd1, 32'hABCD);
        check("bypass_b", rd2, 32'h77);
`else
        check("nobypass_a", rd1, 32'h1111);
        check("nobypass_b", rd2, 32'h0);
`endif
        check("bypass_busy1", busy1, 0);
        tick(); idle();
        #1;
        check("after_r12", rd1, 32'hABCD);
        check("after_r13", rd2, 32'h77);

        // reset overrides a write and a claim to the same register
        we3 = 1'b1; wa3 = 5'd3; wd3 = 32'h42;
        cl  = 1'b1; ca  = 5'd3;
        tick(); idle();
        read1(5'd3);
        check("pre_rst_r3", rd1, 32'h42);
        check("pre_rst_busy3", busy1, 1);
        reset = 1'b1;
        we3 = 1'b1; wa3 = 5'd3; wd3 = 32'hFF;
        cl  = 1'b1; ca  = 5'd3;
        tick(); idle();
        reset = 1'b0;
        ra1 = 5'd3; ra2 = 5'd5; #1;
        check("rst_ovr_r3", rd1, 0);
        check("rst_ovr_busy3", busy1, 0);
        check("rst_ovr_r5", rd2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
